// File: rtl/cphy_pkg.sv
// Shared C-PHY lane types: LP line states, LP transmit sequencer states and
// TxTimer seed selectors.
package cphy_pkg;

    typedef enum logic [1:0] {
        LP11 = 2'b11,
        LP01 = 2'b01,
        LP00 = 2'b00,
        LP10 = 2'b10
    } lp_state_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HS_RQST   = 3'd1,
        HS_PREP   = 3'd2,
        HS_ACTIVE = 3'd3,
        HS_TRAIL  = 3'd4,
        HS_EXIT   = 3'd5,
        TA_RQST   = 3'd6,
        TA_GO     = 3'd7
    } tx_seq_state_e;

    localparam logic TIMER_SEED_LP = 1'b0;
    localparam logic TIMER_SEED_TA = 1'b1;

    // Timed states wait on TxTimer expiry and are covered by the watchdog.
    function automatic logic is_timed(input tx_seq_state_e s);
        return (s != IDLE) && (s != HS_ACTIVE);
    endfunction

endpackage

// File: rtl/cphy_lp_tx_seq.sv
// Master-side LP transmit sequencer: walks LP line states for HS entry/exit and
// bus turnaround, driving TxTimer and guarding every timed state with a watchdog.
module cphy_lp_tx_seq
    import cphy_pkg::*;
#(
    parameter int HS_MIN_CYCLES = 4,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       RstN,
    input  logic       HsReq,
    input  logic       TaReq,
    input  logic       Timeout,
    output logic       TimerEn,
    output logic       TimerSeed,
    output logic [1:0] LpState,
    output logic       LpTxEn,
    output logic       HsTxEn,
    output logic       HsReady,
    output logic       TaDone,
    output logic       WdogErr,
    output logic       Busy
);

    localparam logic [6:0] HS_MIN_LAST = 7'(HS_MIN_CYCLES - 1);
    localparam logic [6:0] WDOG_LAST   = 7'(WDOG_CYCLES - 1);

    tx_seq_state_e state_q, state_d;
    logic [6:0]    dwell_q, dwell_d;
    lp_state_e     lp_state_q, lp_state_d;
    logic          timer_en_q, timer_en_d;
    logic          timer_seed_q, timer_seed_d;
    logic          lp_tx_en_q, lp_tx_en_d;
    logic          hs_tx_en_q, hs_tx_en_d;
    logic          hs_ready_q, hs_ready_d;
    logic          ta_done_q, ta_done_d;
    logic          wdog_err_q, wdog_err_d;
    logic          busy_q, busy_d;
    logic          advance;

    // Timeout only counts once the reload gap is over, i.e. while TimerEn is high.
    assign advance = timer_en_q && Timeout;

    always_comb begin
        state_d    = state_q;
        ta_done_d  = 1'b0;
        wdog_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (HsReq)      state_d = HS_RQST;
                else if (TaReq) state_d = TA_RQST;
            end
            HS_RQST:  if (advance) state_d = HS_PREP;
            HS_PREP:  if (advance) state_d = HS_ACTIVE;
            HS_ACTIVE: begin
                if (!HsReq && (dwell_q >= HS_MIN_LAST)) state_d = HS_TRAIL;
            end
            HS_TRAIL: if (advance) state_d = HS_EXIT;
            HS_EXIT:  if (advance) state_d = IDLE;
            TA_RQST:  if (advance) state_d = TA_GO;
            TA_GO: begin
                if (advance) begin
                    state_d   = IDLE;
                    ta_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timed state that has burned its whole budget without expiry aborts.
        if (is_timed(state_q) && !advance && (dwell_q == WDOG_LAST)) begin
            state_d    = IDLE;
            wdog_err_d = 1'b1;
            ta_done_d  = 1'b0;
        end

        if (state_d != state_q)   dwell_d = 7'd0;
        else if (dwell_q == 7'h7f) dwell_d = dwell_q;
        else                      dwell_d = dwell_q + 7'd1;

        timer_en_d = is_timed(state_d) && (state_d == state_q);

        lp_state_d   = LP11;
        lp_tx_en_d   = 1'b1;
        hs_tx_en_d   = 1'b0;
        timer_seed_d = TIMER_SEED_LP;
        hs_ready_d   = 1'b0;
        busy_d       = (state_d != IDLE);

        // Line outputs are decoded from the next state so they register with it.
        unique case (state_d)
            IDLE:      lp_state_d = LP11;
            HS_RQST:   lp_state_d = LP01;
            HS_PREP:   lp_state_d = LP00;
            HS_ACTIVE: begin
                lp_state_d = LP00;
                lp_tx_en_d = 1'b0;
                hs_tx_en_d = 1'b1;
                hs_ready_d = 1'b1;
            end
            HS_TRAIL: begin
                lp_state_d = LP00;
                lp_tx_en_d = 1'b0;
                hs_tx_en_d = 1'b1;
            end
            HS_EXIT:   lp_state_d = LP11;
            TA_RQST:   lp_state_d = LP10;
            TA_GO: begin
                lp_state_d   = LP00;
                timer_seed_d = TIMER_SEED_TA;
            end
            default:   lp_state_d = LP11;
        endcase
    end

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            state_q      <= IDLE;
            dwell_q      <= 7'd0;
            lp_state_q   <= LP11;
            timer_en_q   <= 1'b0;
            timer_seed_q <= TIMER_SEED_LP;
            lp_tx_en_q   <= 1'b1;
            hs_tx_en_q   <= 1'b0;
            hs_ready_q   <= 1'b0;
            ta_done_q    <= 1'b0;
            wdog_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            lp_state_q   <= lp_state_d;
            timer_en_q   <= timer_en_d;
            timer_seed_q <= timer_seed_d;
            lp_tx_en_q   <= lp_tx_en_d;
            hs_tx_en_q   <= hs_tx_en_d;
            hs_ready_q   <= hs_ready_d;
            ta_done_q    <= ta_done_d;
            wdog_err_q   <= wdog_err_d;
            busy_q       <= busy_d;
        end
    end

    assign TimerEn   = timer_en_q;
    assign TimerSeed = timer_seed_q;
    assign LpState   = lp_state_q;
    assign LpTxEn    = lp_tx_en_q;
    assign HsTxEn    = hs_tx_en_q;
    assign HsReady   = hs_ready_q;
    assign TaDone    = ta_done_q;
    assign WdogErr   = wdog_err_q;
    assign Busy      = busy_q;

endmodule
